// File: rtl/rf_bist.sv
// rf_bist: built-in self test for a 1-write / 2-read register file.
// Each register gets ITERS passes of: write an LFSR pattern, read it back on
// port 0, on port 1, then on both ports at once. Mismatches are counted
// (saturating) and the first failing address is latched.
//
// Ports
//   clk, reset_n            : clock, synchronous active-low reset
//   start, abort            : begin a run (ignored while busy) / stop a run
//   rf_write_en/waddr/wdata : register-file write command
//   rf_read_en[1:0]         : per-port read enable (bit0 port 0, bit1 port 1)
//   rf_raddr_0/1            : read addresses
//   rf_rdata_0/1            : read data, combinational from the register file
//   busy, done, pass        : run status; pass = done with zero errors
//   err_count               : mismatching port reads, saturates at 16'hFFFF
//   first_err_addr/_valid   : address of the first mismatch
module rf_bist #(
  parameter int          DATA_W   = 64,
  parameter int          ADDR_W   = 6,
  parameter int          NUM_REGS = 64,
  parameter int          ITERS    = 64,
  parameter logic [63:0] SEED     = 64'h0123_4567_89AB_CDEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        rf_read_en,
  output logic [ADDR_W-1:0] rf_raddr_0,
  output logic [ADDR_W-1:0] rf_raddr_1,
  input  logic [DATA_W-1:0] rf_rdata_0,
  input  logic [DATA_W-1:0] rf_rdata_1,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid
);

  localparam int                ITER_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);
  // Taps for x^64+x^63+x^61+x^60+1: bits 63, 62, 60, 59.
  localparam logic [63:0]       TAPS      = 64'hD800_0000_0000_0000;
  localparam int                REPS      = (DATA_W + 63) / 64;

  typedef enum logic [2:0] {IDLE, WRITE, RD0, RD1, RDB, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ITER_W-1:0]   iter;
  logic [63:0]         lfsr;
  logic [DATA_W-1:0]   expected;
  logic [REPS*64-1:0]  lfsr_rep;
  logic [DATA_W-1:0]   lfsr_data;
  logic                start_ok;
  logic                last_step;
  logic                miss_0, miss_1;
  logic [1:0]          miss_cnt;
  logic [16:0]         err_sum;

  // Pattern is the LFSR truncated, or replicated when DATA_W exceeds 64.
  assign lfsr_rep  = {REPS{lfsr}};
  assign lfsr_data = lfsr_rep[DATA_W-1:0];

  assign start_ok  = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign last_step = (addr == ADDR_LAST) && (iter == ITER_LAST);

  assign miss_0    = rf_read_en[0] && (rf_rdata_0 != expected);
  assign miss_1    = rf_read_en[1] && (rf_rdata_1 != expected);
  assign miss_cnt  = {1'b0, miss_0} + {1'b0, miss_1};
  assign err_sum   = {1'b0, err_count} + {15'd0, miss_cnt};

  assign busy = (state == WRITE) || (state == RD0) || (state == RD1) || (state == RDB);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rf_write_en = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_read_en  = 2'b00;
    rf_raddr_0  = '0;
    rf_raddr_1  = '0;
    case (state)
      IDLE, DONE: begin
        if (start_ok) state_nxt = WRITE;
      end
      WRITE: begin
        rf_write_en = 1'b1;
        rf_waddr    = addr;
        rf_wdata    = lfsr_data;
        state_nxt   = abort ? IDLE : RD0;
      end
      RD0: begin
        rf_read_en = 2'b01;
        rf_raddr_0 = addr;
        state_nxt  = abort ? IDLE : RD1;
      end
      RD1: begin
        rf_read_en = 2'b10;
        rf_raddr_1 = addr;
        state_nxt  = abort ? IDLE : RDB;
      end
      RDB: begin
        rf_read_en = 2'b11;
        rf_raddr_0 = addr;
        rf_raddr_1 = addr;
        if (abort)          state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
        else                state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr            <= '0;
      iter            <= '0;
      lfsr            <= SEED;
      expected        <= '0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        addr            <= '0;
        iter            <= '0;
        lfsr            <= SEED;
        err_count       <= '0;
        first_err_addr  <= '0;
        first_err_valid <= 1'b0;
      end
      if (state == WRITE) begin
        expected <= lfsr_data;
        lfsr     <= {lfsr[62:0], ^(lfsr & TAPS)};
      end
      if (state == RDB && !last_step) begin
        if (iter == ITER_LAST) begin
          iter <= '0;
          addr <= addr + 1'b1;
        end else begin
          iter <= iter + 1'b1;
        end
      end
      // Read data is checked on the edge leaving each read state, including
      // an aborting edge; start_ok never coincides with a read state.
      if (miss_cnt != 2'd0) begin
        err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (!first_err_valid) begin
          first_err_addr  <= addr;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_bist.sv
`timescale 1ns/1ps
module tb_rf_bist;

  localparam int          DW      = 64;
  localparam int          AW      = 6;
  localparam int          NR      = 64;
  localparam int          IT      = 64;
  localparam logic [63:0] SEED    = 64'h0123_4567_89AB_CDEF;
  localparam int unsigned RUN_LEN = 4 * IT * NR;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [1:0] en; logic [AW-1:0] addr; } rd_t;
  typedef struct { int unsigned len; logic [15:0] err; logic fva; logic [AW-1:0] fea; } res_t;
  typedef struct {
    bit timeout; logic busy, done, pass, wen; logic [1:0] ren;
    bit chk_err; logic [15:0] err; logic fva; logic [AW-1:0] fea;
  } snap_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rf_write_en;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    rf_read_en;
  logic [AW-1:0] rf_raddr_0, rf_raddr_1;
  logic [DW-1:0] rf_rdata_0, rf_rdata_1;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic          first_err_valid;

  rf_bist #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ITERS(IT), .SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_read_en(rf_read_en), .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  // Register-file model with optional data inversion on one register/port.
  logic [DW-1:0] mem [NR];
  logic          f_en = 1'b0, f_p0 = 1'b0, f_p1 = 1'b0;
  logic [AW-1:0] f_reg = '0;

  always @(posedge clk) if (rf_write_en) mem[rf_waddr] <= rf_wdata;

  assign rf_rdata_0 = mem[rf_raddr_0] ^ ((f_en && f_p0 && rf_raddr_0 == f_reg) ? {DW{1'b1}} : {DW{1'b0}});
  assign rf_rdata_1 = mem[rf_raddr_1] ^ ((f_en && f_p1 && rf_raddr_1 == f_reg) ? {DW{1'b1}} : {DW{1'b0}});

  wr_t   exp_wr[$];
  rd_t   exp_rd[$];
  res_t  exp_res[$];
  snap_t exp_snap[$];
  string exp_snap_nm[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event required event", nm);
  endfunction

  function automatic void expect_snap(input string nm, input bit to, input logic b, input logic d,
                                      input logic p, input logic w, input logic [1:0] r, input bit ce,
                                      input logic [15:0] e, input logic v, input logic [AW-1:0] fa);
    snap_t s;
    s.timeout = to; s.busy = b; s.done = d; s.pass = p; s.wen = w; s.ren = r;
    s.chk_err = ce; s.err = e; s.fva = v; s.fea = fa;
    exp_snap.push_back(s);
    exp_snap_nm.push_back(nm);
  endfunction

  // Monitor / scoreboard.
  logic        prev_busy = 1'b0, prev_done = 1'b0;
  int unsigned busy_cycles = 0;

  always @(negedge clk) begin
    wr_t w; rd_t r; res_t q; snap_t s; string nm;
    if (busy && !prev_busy) busy_cycles = 0;
    if (busy) busy_cycles++;

    if (rf_write_en) begin
      if (exp_wr.size() == 0) fail_now("wr_unexpected");
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(rf_waddr), 64'(w.addr));
        chk("wr_data", 64'(rf_wdata), 64'(w.data));
      end
    end else begin
      chk("wdata_idle", 64'(rf_wdata), 64'd0);
    end

    if (rf_read_en != 2'b00) begin
      if (exp_rd.size() == 0) fail_now("rd_unexpected");
      else begin
        r = exp_rd.pop_front();
        chk("rd_en", 64'(rf_read_en), 64'(r.en));
        if (r.en[0]) chk("raddr_0", 64'(rf_raddr_0), 64'(r.addr));
        if (r.en[1]) chk("raddr_1", 64'(rf_raddr_1), 64'(r.addr));
      end
    end else begin
      chk("raddr_idle", {32'd0, 26'd0, rf_raddr_0}, 64'd0);
      chk("raddr_idle", {32'd0, 26'd0, rf_raddr_1}, 64'd0);
    end

    if (done && !prev_done) begin
      if (exp_res.size() == 0) fail_now("done_unexpected");
      else begin
        q = exp_res.pop_front();
        chk("run_len", 64'(busy_cycles), 64'(q.len));
        chk("res_err", 64'(err_count), 64'(q.err));
        chk("res_pass", 64'(pass), 64'(q.err == 16'd0));
        chk("res_fva", 64'(first_err_valid), 64'(q.fva));
        if (q.fva) chk("res_fea", 64'(first_err_addr), 64'(q.fea));
        chk("wr_left", 64'(exp_wr.size()), 64'd0);
        chk("rd_left", 64'(exp_rd.size()), 64'd0);
      end
    end

    while (exp_snap.size() > 0) begin
      s  = exp_snap.pop_front();
      nm = exp_snap_nm.pop_front();
      if (s.timeout) fail_now(nm);
      else begin
        chk({nm, ".busy"}, 64'(busy), 64'(s.busy));
        chk({nm, ".done"}, 64'(done), 64'(s.done));
        chk({nm, ".pass"}, 64'(pass), 64'(s.pass));
        chk({nm, ".wen"}, 64'(rf_write_en), 64'(s.wen));
        chk({nm, ".ren"}, 64'(rf_read_en), 64'(s.ren));
        if (s.chk_err) begin
          chk({nm, ".err"}, 64'(err_count), 64'(s.err));
          chk({nm, ".fva"}, 64'(first_err_valid), 64'(s.fva));
          chk({nm, ".fea"}, 64'(first_err_addr), 64'(s.fea));
        end
      end
    end

    prev_busy = busy;
    prev_done = done;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue the full expected run (write pattern, read sequence, final result)
  // then pulse start for one edge.
  task automatic start_run(input bit fe, input bit p0, input bit p1,
                           input logic [AW-1:0] fr, input bit want_done);
    logic [63:0] l;
    res_t        r;
    int unsigned e;
    f_en = fe; f_p0 = p0; f_p1 = p1; f_reg = fr;
    exp_wr.delete();
    exp_rd.delete();
    l = SEED; e = 0; r.fva = 1'b0; r.fea = '0;
    for (int a = 0; a < NR; a++) begin
      for (int i = 0; i < IT; i++) begin
        exp_wr.push_back('{addr: AW'(a), data: l[DW-1:0]});
        exp_rd.push_back('{en: 2'b01, addr: AW'(a)});
        exp_rd.push_back('{en: 2'b10, addr: AW'(a)});
        exp_rd.push_back('{en: 2'b11, addr: AW'(a)});
        // A faulty port is read twice per iteration: alone and in the dual read.
        if (fe && AW'(a) == fr && (p0 || p1)) begin
          e += (p0 ? 2 : 0) + (p1 ? 2 : 0);
          if (!r.fva) begin r.fva = 1'b1; r.fea = fr; end
        end
        l = lfsr_step(l);
      end
    end
    r.len = RUN_LEN;
    r.err = (e > 65535) ? 16'hFFFF : 16'(e);
    if (want_done) exp_res.push_back(r);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < int'(RUN_LEN) + 100 && !seen; n++) begin
      cyc();
      seen = done;
    end
    if (!seen) begin
      expect_snap({nm, "_timeout"}, 1'b1, 0, 0, 0, 0, 2'b00, 1'b0, '0, 0, '0);
      exp_res.delete();
    end
  endtask

  initial begin
    int unsigned    k, hits, sel;
    bit             found;
    logic [AW-1:0]  rr;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    expect_snap("reset", 1'b0, 0, 0, 0, 0, 2'b00, 1'b1, 16'd0, 0, '0);

    // Ideal register file; a second start during the run must be ignored.
    start_run(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done("ideal");
    repeat (5) cyc();
    expect_snap("done_held", 1'b0, 0, 1, 1, 0, 2'b00, 1'b1, 16'd0, 0, '0);

    // Port 0 of register 10 returns inverted data.
    start_run(1'b1, 1'b1, 1'b0, AW'(10), 1'b1);
    wait_done("reg10");
    cyc();
    expect_snap("reg10_fault", 1'b0, 0, 1, 0, 0, 2'b00, 1'b1, 16'd128, 1, AW'(10));

    // Abort while the 101st busy cycle (a WRITE) is active; register 0 port 0
    // is faulty, so 25 completed iterations leave 50 errors behind.
    start_run(1'b1, 1'b1, 1'b0, AW'(0), 1'b0);
    repeat (100) @(posedge clk);
    #1 abort = 1'b1;
    cyc();
    abort = 1'b0;
    expect_snap("abort", 1'b0, 0, 0, 0, 0, 2'b00, 1'b1, 16'd50, 1, AW'(0));
    repeat (3) cyc();
    expect_snap("abort_hold", 1'b0, 0, 0, 0, 0, 2'b00, 1'b1, 16'd50, 1, AW'(0));
    exp_wr.delete();
    exp_rd.delete();

    // Reset during a randomly chosen dual read of register 5.
    start_run(1'b0, 1'b0, 1'b0, '0, 1'b0);
    k = $urandom_range(1, IT);
    hits = 0;
    found = 1'b0;
    for (int n = 0; n < int'(RUN_LEN) && !found; n++) begin
      @(negedge clk);
      if (rf_read_en == 2'b11 && rf_raddr_0 == AW'(5)) begin
        hits++;
        if (hits == k) found = 1'b1;
      end
    end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    if (!found) expect_snap("rdb5_timeout", 1'b1, 0, 0, 0, 0, 2'b00, 1'b0, '0, 0, '0);
    else        expect_snap("mid_reset", 1'b0, 0, 0, 0, 0, 2'b00, 1'b1, 16'd0, 0, '0);
    exp_wr.delete();
    exp_rd.delete();
    cyc();
    start_run(1'b0, 1'b0, 1'b0, '0, 1'b1);
    wait_done("after_reset");
    cyc();
    expect_snap("after_reset_pass", 1'b0, 0, 1, 1, 0, 2'b00, 1'b1, 16'd0, 0, '0);

    // Random faulty register with a random non-empty set of faulty ports.
    rr  = AW'($urandom_range(0, NR - 1));
    sel = $urandom_range(1, 3);
    start_run(1'b1, sel[0], sel[1], rr, 1'b1);
    wait_done("random_fault");

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
